noc_credit_tx: RTL

- Transmit-side endpoint of the rtr-to-rtr credit link: data/dest/is_tail/send forward, one credit pulse back.
- Turns a valid/ready flit stream into registered send pulses, gated by a credit counter that mirrors the downstream router input FIFO.
- Framing FSM holds dest constant across every flit of a packet.
- Used wherever a router input port is driven: injection shims, test traffic generators, inter-router pipelines.

---
 rtl/noc_link_pkg.sv | 10 +
 rtl/noc_credit_tx_if.sv | 26 ++
 rtl/noc_credit_counter.sv | 41 ++++
 rtl/noc_credit_tx.sv | 101 ++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the router-to-router credit link.
package noc_link_pkg;

  typedef enum logic {TX_HEAD, TX_BODY} tx_state_t;

  function automatic int credit_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_tx_if.sv
// Flit handshake and link-side signals of the credit transmitter.
interface noc_credit_tx_if #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEST_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_is_tail;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;

  modport slave (
    input  in_valid, in_data, in_dest, in_is_tail, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport master (
    output in_valid, in_data, in_dest, in_is_tail, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_credit_counter.sv
// Saturating up/down credit counter that starts full and flags overflow stickily.
module noc_credit_counter
  import noc_link_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = credit_cnt_width(DEPTH)
) (
  input  logic          clk_noc,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_count;
  logic          r_err;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= FULL;
      r_err   <= 1'b0;
    end else begin
      unique case ({dec, inc})
        2'b10: if (r_count != '0) r_count <= r_count - CW'(1);
        2'b01: begin
          // A credit beyond the downstream FIFO depth is a protocol error: clamp and remember it.
          if (r_count == FULL) r_err   <= 1'b1;
          else                 r_count <= r_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign count = r_count;
  assign err   = r_err;

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-gated flit transmitter with packet framing; NOC_CREDIT_TX_STATS_EN adds flit/stall counters.
module noc_credit_tx
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH         = credit_cnt_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                 clk_noc,
  input  logic                 rst_n,
  noc_credit_tx_if.slave       link,
  output logic [CNT_WIDTH-1:0] credit_count,
  output logic                 in_packet,
`ifdef NOC_CREDIT_TX_STATS_EN
  output logic [31:0]          flit_count,
  output logic [31:0]          stall_count,
`endif
  output logic                 credit_err
);

  logic [CNT_WIDTH-1:0]  w_count;
  logic                  w_ready;
  logic                  w_accept;

  tx_state_t             r_state;
  logic                  r_send;
  logic                  r_tail;
  logic [FLIT_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .CW    (CNT_WIDTH)
  ) u_credit (
    .clk_noc (clk_noc),
    .rst_n   (rst_n),
    .dec     (w_accept),
    .inc     (link.credit_in),
    .count   (w_count),
    .err     (credit_err)
  );

  // Ready looks only at the registered count so a same-cycle credit cannot form a comb path.
  assign w_ready  = (w_count != '0);
  assign w_accept = link.in_valid && w_ready;

  // The latched head dest doubles as the dest_out register: in BODY both hold the same value.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= TX_HEAD;
      r_send  <= 1'b0;
      r_tail  <= 1'b0;
      r_data  <= '0;
      r_dest  <= '0;
    end else begin
      r_send <= w_accept;
      if (w_accept) begin
        r_data <= link.in_data;
        r_tail <= link.in_is_tail;
        unique case (r_state)
          TX_HEAD: begin
            r_dest <= link.in_dest;
            if (!link.in_is_tail) r_state <= TX_BODY;
          end
          TX_BODY: begin
            if (link.in_is_tail) r_state <= TX_HEAD;
          end
          default: r_state <= TX_HEAD;
        endcase
      end
    end
  end

`ifdef NOC_CREDIT_TX_STATS_EN
  logic [31:0] r_flit_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept)                    r_flit_cnt  <= r_flit_cnt + 32'd1;
      if (link.in_valid && !w_ready)   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign flit_count  = r_flit_cnt;
  assign stall_count = r_stall_cnt;
`endif

  assign link.in_ready    = w_ready;
  assign link.send_out    = r_send;
  assign link.data_out    = r_data;
  assign link.dest_out    = r_dest;
  assign link.is_tail_out = r_tail;
  assign credit_count     = w_count;
  assign in_packet        = (r_state == TX_BODY);

endmodule
